// File: rtl/versatile_mem_ctrl_sdram_port.sv
`default_nettype none
// ============================================================================
// Module   : versatile_mem_ctrl_sdram_port
// Purpose  : SDRAM-clock-side drain/fill engine. Round-robin picks a non-empty
//            egress queue, pops a command header (plus write data words),
//            runs the single/burst transaction on a req/ack memory core and
//            pushes read data into the matching ingress queue.
// Revision : 1.0  initial release
// ============================================================================
module versatile_mem_ctrl_sdram_port #(
    parameter int nr_of_wb_ports = 3,
    parameter int linear_len     = 8
) (
    input  logic                        sdram_clk,
    input  logic                        sdram_rst,
    input  logic [35:0]                 egress_dat_i,
    input  logic [0:nr_of_wb_ports-1]   egress_empty_i,
    output logic [0:nr_of_wb_ports-1]   egress_rd_o,
    output logic [31:0]                 ingress_dat_o,
    output logic [0:nr_of_wb_ports-1]   ingress_wr_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [29:0]                 mem_adr_o,
    output logic [31:0]                 mem_dat_o,
    output logic [3:0]                  mem_sel_o,
    output logic                        mem_last_o,
    input  logic                        mem_ack_i,
    input  logic [31:0]                 mem_dat_i,
    output logic                        busy_o
);

    localparam int PTR_W = (nr_of_wb_ports > 1) ? $clog2(nr_of_wb_ports) : 1;

    // HPOP and WPOPD are the cycles in which the pop strobe is visible; the
    // popped word is then valid on egress_dat_i in the following state.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HPOP  = 4'd1,
        S_HDR   = 4'd2,
        S_WPOP  = 4'd3,
        S_WPOPD = 4'd4,
        S_WDAT  = 4'd5,
        S_WACK  = 4'd6,
        S_RREQ  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t                     state_q;
    logic [PTR_W-1:0]           ptr_q;
    logic [PTR_W-1:0]           grant_q;
    logic [4:0]                 count_q;
    logic                       wrap_q;
    logic [3:0]                 mask_q;
    logic [0:nr_of_wb_ports-1]  egress_rd_q;
    logic [0:nr_of_wb_ports-1]  ingress_wr_q;
    logic [31:0]                ingress_dat_q;
    logic                       mem_req_q;
    logic                       mem_we_q;
    logic [29:0]                mem_adr_q;
    logic [31:0]                mem_dat_q;
    logic [3:0]                 mem_sel_q;
    logic                       mem_last_q;
    logic                       busy_q;

    logic                       found_d;
    logic [PTR_W-1:0]           grant_d;
    logic [PTR_W:0]             rr_sum;
    logic [4:0]                 hdr_len_d;
    logic                       hdr_wrap_d;
    logic [29:0]                adr_step_d;
    logic                       ack_seen;

    // One-hot strobe for a port index
    function automatic logic [0:nr_of_wb_ports-1] port_onehot(input logic [PTR_W-1:0] g);
        logic [0:nr_of_wb_ports-1] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Circular search for the first non-empty port at or after the pointer
    always_comb begin
        found_d = 1'b0;
        grant_d = '0;
        rr_sum  = '0;
        for (int i = 0; i < nr_of_wb_ports; i++) begin
            rr_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (rr_sum >= (PTR_W+1)'(nr_of_wb_ports)) begin
                rr_sum = rr_sum - (PTR_W+1)'(nr_of_wb_ports);
            end
            if (!found_d && !egress_empty_i[rr_sum[PTR_W-1:0]]) begin
                found_d = 1'b1;
                grant_d = rr_sum[PTR_W-1:0];
            end
        end
    end

    // Burst length and wrap flag decoded from the header currently on egress_dat_i
    always_comb begin
        hdr_len_d  = 5'd1;
        hdr_wrap_d = 1'b0;
        if (egress_dat_i[2:0] == 3'b010) begin
            hdr_wrap_d = (egress_dat_i[4:3] != 2'b00);
            case (egress_dat_i[4:3])
                2'b01:   hdr_len_d = 5'd4;
                2'b10:   hdr_len_d = 5'd8;
                2'b11:   hdr_len_d = 5'd16;
                default: hdr_len_d = 5'(linear_len);
            endcase
        end
    end

    // Next word address: wrap bursts only move the low bits selected by mask_q
    always_comb begin
        adr_step_d = mem_adr_q + 30'd1;
        if (wrap_q) begin
            adr_step_d = (mem_adr_q & ~{26'd0, mask_q}) | (adr_step_d & {26'd0, mask_q});
        end
    end

    assign ack_seen = mem_ack_i && mem_req_q;

    // Transaction sequencer; all outputs are registered here
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            count_q       <= '0;
            wrap_q        <= 1'b0;
            mask_q        <= '0;
            egress_rd_q   <= '0;
            ingress_wr_q  <= '0;
            ingress_dat_q <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_adr_q     <= '0;
            mem_dat_q     <= '0;
            mem_sel_q     <= '0;
            mem_last_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            egress_rd_q  <= '0;
            ingress_wr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        grant_q     <= grant_d;
                        egress_rd_q <= port_onehot(grant_d);
                        busy_q      <= 1'b1;
                        state_q     <= S_HPOP;
                    end
                end
                S_HPOP: begin
                    state_q <= S_HDR;
                end
                S_HDR: begin
                    mem_adr_q <= egress_dat_i[35:6];
                    count_q   <= hdr_len_d;
                    wrap_q    <= hdr_wrap_d;
                    mask_q    <= 4'(hdr_len_d - 5'd1);
                    if (egress_dat_i[5]) begin
                        state_q <= S_WPOP;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_sel_q  <= 4'hF;
                        mem_last_q <= (hdr_len_d == 5'd1);
                        state_q    <= S_RREQ;
                    end
                end
                S_WPOP: begin
                    if (!egress_empty_i[grant_q]) begin
                        egress_rd_q <= port_onehot(grant_q);
                        state_q     <= S_WPOPD;
                    end
                end
                S_WPOPD: begin
                    state_q <= S_WDAT;
                end
                S_WDAT: begin
                    mem_dat_q  <= egress_dat_i[35:4];
                    mem_sel_q  <= egress_dat_i[3:0];
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b1;
                    mem_last_q <= (count_q == 5'd1);
                    state_q    <= S_WACK;
                end
                S_WACK: begin
                    if (ack_seen) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_last_q <= 1'b0;
                        count_q    <= count_q - 5'd1;
                        mem_adr_q  <= adr_step_d;
                        if (count_q == 5'd1) begin
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else if (!egress_empty_i[grant_q]) begin
                            // Last pop was two cycles ago, so the flag is settled
                            egress_rd_q <= port_onehot(grant_q);
                            state_q     <= S_WPOPD;
                        end else begin
                            state_q <= S_WPOP;
                        end
                    end
                end
                S_RREQ: begin
                    if (ack_seen) begin
                        ingress_dat_q <= mem_dat_i;
                        ingress_wr_q  <= port_onehot(grant_q);
                        count_q       <= count_q - 5'd1;
                        mem_adr_q     <= adr_step_d;
                        mem_last_q    <= (count_q == 5'd2);
                        if (count_q == 5'd1) begin
                            mem_req_q  <= 1'b0;
                            mem_last_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (grant_q == PTR_W'(nr_of_wb_ports - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= grant_q + 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign egress_rd_o   = egress_rd_q;
    assign ingress_wr_o  = ingress_wr_q;
    assign ingress_dat_o = ingress_dat_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_adr_o     = mem_adr_q;
    assign mem_dat_o     = mem_dat_q;
    assign mem_sel_o     = mem_sel_q;
    assign mem_last_o    = mem_last_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_versatile_mem_ctrl_sdram_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_versatile_mem_ctrl_sdram_port
// Purpose  : Self-checking bench: egress FIFO / memory-core models, randomized
//            transactions compared against a burst/address reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_versatile_mem_ctrl_sdram_port;

    localparam int N  = 3;
    localparam int LL = 8;

    logic              sdram_clk = 1'b0;
    logic              sdram_rst = 1'b1;
    logic [35:0]       egress_dat_i = '0;
    logic [0:N-1]      egress_empty_i = '1;
    logic [0:N-1]      egress_rd_o;
    logic [31:0]       ingress_dat_o;
    logic [0:N-1]      ingress_wr_o;
    logic              mem_req_o, mem_we_o, mem_last_o, busy_o;
    logic [29:0]       mem_adr_o;
    logic [31:0]       mem_dat_o;
    logic [3:0]        mem_sel_o;
    logic              mem_ack_i = 1'b0;
    logic [31:0]       mem_dat_i = '0;

    always #5 sdram_clk = ~sdram_clk;

    versatile_mem_ctrl_sdram_port #(.nr_of_wb_ports(N), .linear_len(LL)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .egress_dat_i(egress_dat_i), .egress_empty_i(egress_empty_i), .egress_rd_o(egress_rd_o),
        .ingress_dat_o(ingress_dat_o), .ingress_wr_o(ingress_wr_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
        .mem_sel_o(mem_sel_o), .mem_last_o(mem_last_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i),
        .busy_o(busy_o));

    logic [107:0] all_outs;
    assign all_outs = {egress_rd_o, ingress_wr_o, ingress_dat_o, mem_req_o, mem_we_o, mem_adr_o,
                       mem_dat_o, mem_sel_o, mem_last_o, busy_o};

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        last;
        logic [31:0] rdat;
        int          cyc;
    } mem_t;
    typedef struct {
        int          port;
        logic [31:0] dat;
    } ing_t;

    logic [35:0] fifo [N][$];
    mem_t        memlog[$];
    ing_t        inglog[$];
    int          grant_log[$];
    int          pops[N], last_pop_cyc[N], fall_cyc[N];
    int          cyc = 0;
    logic [35:0] pend_w;
    bit          pend_v = 0;
    bit          prev_busy = 0;
    int          ack_mode = 0, stall_cnt = 0;
    int          stable_err = 0, onehot_err = 0, pop_empty_err = 0, stall_pop_err = 0;
    mem_t        prv;
    bit          prv_req = 0, prv_ack = 0;
    int          checks = 0, errors = 0;
    int          exp_len;
    logic [31:0] exp_wd[16];
    logic [3:0]  exp_ws[16];

    // Egress RAM/flags, memory core and ingress observers, all acting on the falling edge
    always @(negedge sdram_clk) begin
        mem_t e;
        bit   ne;
        cyc = cyc + 1;
        if (pend_v) begin
            egress_dat_i = pend_w;
            pend_v = 0;
        end else begin
            egress_dat_i = {32'($urandom), 4'($urandom)};
        end
        if ($countones(egress_rd_o) > 1) onehot_err++;
        if (stall_cnt > 0 && ack_mode == 2 && mem_req_o && egress_rd_o != '0) stall_pop_err++;
        for (int p = 0; p < N; p++) begin
            if (egress_rd_o[p]) begin
                if (fifo[p].size() == 0) pop_empty_err++;
                else begin
                    pend_w = fifo[p].pop_front();
                    pend_v = 1;
                end
                pops[p]++;
                last_pop_cyc[p] = cyc;
                if (!prev_busy) grant_log.push_back(p);
            end
        end
        prev_busy = busy_o;
        for (int p = 0; p < N; p++) begin
            ne = (fifo[p].size() == 0);
            if (egress_empty_i[p] && !ne) fall_cyc[p] = cyc;
            egress_empty_i[p] = ne;
        end
        if (prv_req && !prv_ack) begin
            if (!mem_req_o || mem_adr_o !== prv.adr || mem_dat_o !== prv.dat ||
                mem_sel_o !== prv.sel || mem_we_o !== prv.we || mem_last_o !== prv.last)
                stable_err++;
        end
        if (mem_req_o) begin
            case (ack_mode)
                0: mem_ack_i = 1'b1;
                1: mem_ack_i = 1'($urandom_range(1, 0));
                default: begin
                    if (stall_cnt > 0) begin
                        mem_ack_i = 1'b0;
                        stall_cnt--;
                    end else mem_ack_i = 1'b1;
                end
            endcase
        end else begin
            mem_ack_i = 1'($urandom_range(1, 0));
        end
        mem_dat_i = $urandom;
        e.we = mem_we_o; e.adr = mem_adr_o; e.dat = mem_dat_o; e.sel = mem_sel_o;
        e.last = mem_last_o; e.rdat = mem_dat_i; e.cyc = cyc;
        if (mem_req_o && mem_ack_i) memlog.push_back(e);
        prv = e; prv_req = mem_req_o; prv_ack = mem_ack_i;
        if ($countones(ingress_wr_o) > 1) onehot_err++;
        for (int p = 0; p < N; p++) begin
            if (ingress_wr_o[p]) begin
                ing_t g;
                g.port = p; g.dat = ingress_dat_o;
                inglog.push_back(g);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_len(input logic [2:0] cti, input logic [1:0] bte);
        if (cti != 3'b010) return 1;
        case (bte)
            2'd1: return 4;
            2'd2: return 8;
            2'd3: return 16;
            default: return LL;
        endcase
    endfunction

    function automatic logic [29:0] ref_adr(input logic [29:0] a, input logic [2:0] cti,
                                            input logic [1:0] bte, input int k);
        longint av, off, l;
        av = longint'(a);
        l  = longint'(ref_len(cti, bte));
        if (cti == 3'b010 && bte != 2'd0) begin
            off = av % l;
            return 30'((av - off) + ((off + k) % l));
        end
        return 30'((av + k) % (longint'(1) << 30));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sdram_clk); #2;
    endtask

    function automatic bit fifos_empty();
        for (int p = 0; p < N; p++) if (fifo[p].size() != 0) return 0;
        return 1;
    endfunction

    task automatic clear_logs();
        memlog.delete(); inglog.delete(); grant_log.delete();
        for (int p = 0; p < N; p++) pops[p] = 0;
        stable_err = 0; onehot_err = 0; pop_empty_err = 0; stall_pop_err = 0;
    endtask

    task automatic push_txn(input int p, input logic [29:0] a, input logic we,
                            input logic [1:0] bte, input logic [2:0] cti);
        exp_len = ref_len(cti, bte);
        fifo[p].push_back({a, we, bte, cti});
        if (we) begin
            for (int k = 0; k < exp_len; k++) begin
                exp_wd[k] = $urandom;
                exp_ws[k] = 4'($urandom);
                fifo[p].push_back({exp_wd[k], exp_ws[k]});
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        int idle;
        idle = 0; ok = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!busy_o && !pend_v && fifos_empty()) idle++; else idle = 0;
            if (idle >= 4) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        sdram_rst = 1'b1;
        for (int p = 0; p < N; p++) fifo[p].delete();
        pend_v = 0;
        tick(); tick();
        sdram_rst = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sdram_rst = 1'b1;
        tick(); tick();
        checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
        sdram_rst = 1'b0;
        tick(); tick();
        checks++; if (busy_o !== 1'b0 || egress_rd_o !== '0) begin errors++; $display("FAIL reset_idle: busy %b rd %b want 0", busy_o, egress_rd_o); end
    endtask

    task automatic test_classic_write();
        bit ok;
        clear_logs();
        fifo[1].push_back({30'h100, 1'b1, 2'b00, 3'b000});
        fifo[1].push_back({32'hDEADBEEF, 4'hF});
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL classic_timeout: got busy %b want done", busy_o); end
        checks++; if (pops[1] !== 2) begin errors++; $display("FAIL classic_pops: got %0d want 2", pops[1]); end
        checks++; if (memlog.size() !== 1) begin errors++; $display("FAIL classic_words: got %0d want 1", memlog.size()); end
        else begin
            checks++;
            if ({memlog[0].we, memlog[0].adr, memlog[0].dat, memlog[0].sel, memlog[0].last} !==
                {1'b1, 30'h100, 32'hDEADBEEF, 4'hF, 1'b1}) begin
                errors++; $display("FAIL classic_word: got we %b adr %h dat %h sel %h last %b want 1 100 deadbeef f 1",
                                   memlog[0].we, memlog[0].adr, memlog[0].dat, memlog[0].sel, memlog[0].last);
            end
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL classic_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_wrap4_read();
        bit ok;
        logic [29:0] want[4];
        want[0] = 30'h0A2; want[1] = 30'h0A3; want[2] = 30'h0A0; want[3] = 30'h0A1;
        clear_logs();
        ack_mode = 0;
        push_txn(0, 30'h0A2, 1'b0, 2'b01, 3'b010);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap4_timeout: got busy %b want done", busy_o); end
        checks++; if (memlog.size() !== 4 || inglog.size() !== 4) begin
            errors++; $display("FAIL wrap4_count: got %0d/%0d want 4/4", memlog.size(), inglog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (memlog[k].adr !== want[k] || memlog[k].last !== (k == 3) || memlog[k].we !== 1'b0 ||
                    memlog[k].sel !== 4'hF || memlog[k].cyc !== memlog[0].cyc + k) begin
                    errors++; $display("FAIL wrap4_word%0d: got adr %h last %b sel %h cyc %0d want adr %h last %b sel f cyc %0d",
                                       k, memlog[k].adr, memlog[k].last, memlog[k].sel, memlog[k].cyc, want[k], k == 3, memlog[0].cyc + k);
                end
                checks++;
                if (inglog[k].port !== 0 || inglog[k].dat !== memlog[k].rdat) begin
                    errors++; $display("FAIL wrap4_ingress%0d: got port %0d dat %h want port 0 dat %h",
                                       k, inglog[k].port, inglog[k].dat, memlog[k].rdat);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        bit seen;
        do_reset();
        clear_logs();
        ack_mode = 1;
        push_txn(0, 30'($urandom), 1'b0, 2'b00, 3'b000);
        push_txn(2, 30'($urandom), 1'b0, 2'b00, 3'b000);
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            tick();
            if (grant_log.size() >= 1 && !busy_o) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rr_first_timeout: got grants %0d want 1", grant_log.size()); end
        push_txn(0, 30'($urandom), 1'b0, 2'b00, 3'b000);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got busy %b want done", busy_o); end
        checks++;
        if (grant_log.size() !== 3) begin
            errors++; $display("FAIL rr_order: got %0d grants want 3", grant_log.size());
        end else if (grant_log[0] !== 0 || grant_log[1] !== 2 || grant_log[2] !== 0) begin
            errors++; $display("FAIL rr_order: got %0d,%0d,%0d want 0,2,0", grant_log[0], grant_log[1], grant_log[2]);
        end
        checks++;
        if (inglog.size() !== 3 || inglog[0].port !== 0 || inglog[1].port !== 2 || inglog[2].port !== 0) begin
            errors++; $display("FAIL rr_ingress: got %0d pushes want ports 0,2,0", inglog.size());
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int bad;
        bit got;
        logic [31:0] d;
        clear_logs();
        ack_mode = 0;
        fifo[1].push_back({30'h1234, 1'b1, 2'b00, 3'b000});
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            if (pops[1] == 1) got = 1;
        end
        checks++; if (!got) begin errors++; $display("FAIL underrun_hdr: got %0d pops want 1", pops[1]); end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (pops[1] != 1 || mem_req_o !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL underrun_hold: got %0d bad cycles want 0", bad); end
        d = $urandom;
        fifo[1].push_back({d, 4'h5});
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL underrun_timeout: got busy %b want done", busy_o); end
        checks++; if (last_pop_cyc[1] !== fall_cyc[1] + 1) begin
            errors++; $display("FAIL underrun_pop_latency: got cycle %0d want %0d", last_pop_cyc[1], fall_cyc[1] + 1);
        end
        checks++; if (memlog.size() !== 1 || memlog[0].dat !== d || memlog[0].sel !== 4'h5 || memlog[0].adr !== 30'h1234) begin
            errors++; $display("FAIL underrun_word: got %0d words want 1 with dat %h sel 5 adr 1234", memlog.size(), d);
        end
        checks++; if (pop_empty_err !== 0) begin errors++; $display("FAIL underrun_empty_pop: got %0d want 0", pop_empty_err); end
    endtask

    task automatic test_ack_stall();
        bit ok;
        int bad;
        logic [29:0] a;
        clear_logs();
        a = 30'($urandom);
        ack_mode = 2;
        stall_cnt = 4;
        push_txn(2, a, 1'b1, 2'b10, 3'b010);
        wait_done(ok);
        ack_mode = 0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got busy %b want done", busy_o); end
        checks++; if (stall_cnt !== 0 || stable_err !== 0) begin
            errors++; $display("FAIL stall_stable: got stall_left %0d unstable %0d want 0 0", stall_cnt, stable_err);
        end
        checks++; if (pops[2] !== 9 || stall_pop_err !== 0) begin
            errors++; $display("FAIL stall_pops: got %0d pops %0d during stall want 9 0", pops[2], stall_pop_err);
        end
        checks++; if (memlog.size() !== 8) begin errors++; $display("FAIL stall_words: got %0d want 8", memlog.size()); end
        else begin
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                if (memlog[k].adr !== ref_adr(a, 3'b010, 2'b10, k) || memlog[k].dat !== exp_wd[k] ||
                    memlog[k].sel !== exp_ws[k] || memlog[k].we !== 1'b1 || memlog[k].last !== (k == 7)) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL stall_content: got %0d bad words want 0", bad); end
        end
    endtask

    task automatic test_linear_reset();
        bit ok;
        bit got;
        clear_logs();
        ack_mode = 0;
        push_txn(0, 30'($urandom), 1'b0, 2'b00, 3'b000);
        wait_done(ok);
        clear_logs();
        push_txn(1, 30'h3FFFFFFF, 1'b0, 2'b00, 3'b010);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (memlog.size() >= 3) got = 1;
        end
        checks++; if (!got) begin errors++; $display("FAIL linear_timeout: got %0d acks want 3", memlog.size()); end
        sdram_rst = 1'b1;
        #1;
        checks++; if (all_outs !== '0) begin errors++; $display("FAIL async_reset_outputs: got %h want 0", all_outs); end
        checks++;
        if (memlog.size() < 3 || memlog[0].adr !== 30'h3FFFFFFF || memlog[1].adr !== 30'h0 || memlog[2].adr !== 30'h1) begin
            errors++; $display("FAIL linear_wrap: got %0d words want adr 3fffffff,0,1", memlog.size());
        end
        for (int p = 0; p < N; p++) fifo[p].delete();
        pend_v = 0;
        tick(); tick();
        sdram_rst = 1'b0;
        tick();
        clear_logs();
        push_txn(1, 30'($urandom), 1'b0, 2'b00, 3'b000);
        push_txn(0, 30'($urandom), 1'b0, 2'b00, 3'b000);
        wait_done(ok);
        checks++; if (!ok || grant_log.size() !== 2 || grant_log[0] !== 0) begin
            errors++; $display("FAIL reset_pointer: got %0d grants first %0d want 2 first 0",
                               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_random();
        bit ok;
        int p, bad;
        logic we;
        logic [1:0] bte;
        logic [2:0] cti;
        logic [29:0] a;
        logic [2:0] cti_set[6];
        cti_set[0] = 3'b000; cti_set[1] = 3'b111; cti_set[2] = 3'b010;
        cti_set[3] = 3'b010; cti_set[4] = 3'b001; cti_set[5] = 3'b110;
        for (int t = 0; t < 24; t++) begin
            clear_logs();
            p   = $urandom_range(N - 1, 0);
            we  = 1'($urandom);
            bte = 2'($urandom);
            cti = cti_set[$urandom_range(5, 0)];
            a   = 30'($urandom);
            ack_mode = $urandom_range(1, 0);
            push_txn(p, a, we, bte, cti);
            wait_done(ok);
            bad = 0;
            if (!ok || memlog.size() != exp_len) bad++;
            else begin
                for (int k = 0; k < exp_len; k++) begin
                    if (memlog[k].adr !== ref_adr(a, cti, bte, k) || memlog[k].we !== we ||
                        memlog[k].last !== (k == exp_len - 1)) bad++;
                    if (we && (memlog[k].dat !== exp_wd[k] || memlog[k].sel !== exp_ws[k])) bad++;
                    if (!we && memlog[k].sel !== 4'hF) bad++;
                end
            end
            checks++; if (bad !== 0) begin
                errors++; $display("FAIL random_mem t%0d: got %0d bad (%0d words) want 0 (%0d words)", t, bad, memlog.size(), exp_len);
            end
            bad = 0;
            if (we) begin
                if (inglog.size() != 0) bad++;
            end else if (inglog.size() != exp_len || memlog.size() != exp_len) bad++;
            else begin
                for (int k = 0; k < exp_len; k++)
                    if (inglog[k].port !== p || inglog[k].dat !== memlog[k].rdat) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL random_ingress t%0d: got %0d bad want 0", t, bad); end
            checks++;
            if (pops[p] !== 1 + (we ? exp_len : 0) || grant_log.size() !== 1 || onehot_err !== 0 ||
                pop_empty_err !== 0 || stable_err !== 0) begin
                errors++; $display("FAIL random_proto t%0d: got pops %0d grants %0d onehot %0d emptypop %0d unstable %0d want %0d 1 0 0 0",
                                   t, pops[p], grant_log.size(), onehot_err, pop_empty_err, stable_err, 1 + (we ? exp_len : 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_classic_write();
        test_wrap4_read();
        test_round_robin();
        test_underrun();
        test_ack_stall();
        test_linear_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/versatile_mem_ctrl_sdram_port.md
Name: versatile_mem_ctrl_sdram_port

Overview:
- SDRAM-clock-side drain/fill engine for the multi-port wishbone egress/ingress FIFOs.
- Round-robin selects a non-empty egress queue and pops the command header, then any write data words.
- Executes the resulting single or burst transaction on a simple req/ack memory-core interface.
- Pushes read data into the matching ingress queue.

Parameters:
- nr_of_wb_ports, 3, number of wishbone ports / FIFO pairs (1..16).
- linear_len, 8, burst length used for linear incrementing bursts (cti=010, bte=00), 1..16.

Ports:
- sdram_clk  in  1  sole clock.
- sdram_rst  in  1  asynchronous, active-high reset.
- egress_dat_i  in  36  egress dual-port RAM read data; valid the cycle after the corresponding pop.
- egress_empty_i  in  [0:nr_of_wb_ports-1]  per-port egress empty flags.
- egress_rd_o  out  [0:nr_of_wb_ports-1]  one-hot pop strobe, at most one bit high.
- ingress_dat_o  out  32  read data to ingress RAM.
- ingress_wr_o  out  [0:nr_of_wb_ports-1]  one-hot push strobe.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1=write.
- mem_adr_o  out  30  word address.
- mem_dat_o  out  32  write data.
- mem_sel_o  out  4  byte selects.
- mem_last_o  out  1  final word of transaction.
- mem_ack_i  in  1  word accepted; on reads mem_dat_i valid same cycle.
- mem_dat_i  in  32  read data.
- busy_o  out  1  high from header pop until transaction end.

Behaviour:
- Header word format: [35:6] word address; [5] WE; [4:3] BTE; [2:0] CTI.
- Write data word format: [35:4] data; [3:0] sel.
- Reset (async):
  - FSM to IDLE and round-robin pointer to port 0.
  - All outputs 0; ingress_dat_o 0.
- All outputs are registered.
- Burst length L:
  - cti 000 or 111 gives L=1.
  - cti 010 with bte 01/10/11 gives L=4/8/16.
  - cti 010 with bte 00 gives L=linear_len.
  - Any other cti gives L=1.
- Address step:
  - Wrap bursts increment the low log2(L) bits modulo L; upper bits are held.
  - Linear bursts increment the full 30-bit address, modulo 2^30.
- Reads set mem_sel_o=4'hF.
- FSM:
  - IDLE: if any egress_empty_i bit is low, grant the first non-empty port at or after the pointer (circular). Pulse egress_rd_o[grant] for 1 cycle and go to HDR.
  - HDR: latch header from egress_dat_i and set count=L. WE=1 goes to WPOP; WE=0 goes to RREQ.
  - WPOP: wait until egress_empty_i[grant]=0, then pulse pop and go to WDAT. No pop while empty.
  - WDAT: latch data/sel and assert mem_req_o, mem_we_o=1, mem_last_o=(count==1). Go to WACK.
  - WACK: hold all mem outputs stable until mem_ack_i. On ack, deassert req the next cycle, decrement count and step address. count 0 goes to DONE; otherwise go to WPOP.
  - RREQ: assert mem_req_o with mem_we_o=0 and mem_last_o=(count==1) until mem_ack_i.
    - Each ack: register mem_dat_i to ingress_dat_o and pulse ingress_wr_o[grant] for exactly 1 cycle (next cycle).
    - Each ack also decrements count and steps the address; req stays high across words.
    - count 0 goes to DONE.
  - DONE: pointer = grant+1 modulo nr_of_wb_ports; busy_o low; go to IDLE.
- Timing rules:
  - Pop-to-data latency is 1 cycle.
  - An empty flag is never sampled in the cycle immediately after a pop of the same port. This covers the async flag update lag.
  - Minimum write word period is 3 cycles; reads sustain 1 word per cycle at mem_ack_i=1.
- No preemption: a granted port keeps the engine until its transaction ends, whatever other ports request.
- Ingress overflow is precluded by L<=16 equalling ingress depth; no full check is made.
- mem_ack_i while mem_req_o=0 is ignored.
- A wrap16 write stalls naturally on egress empty while the wishbone side refills.
- Reset mid-transaction: outputs clear immediately and the partial burst is abandoned; the FIFOs are reset by their owners.

Test Plan:
- Classic write, port 1:
  - Stimulus: header adr=0x100, WE=1, cti=000, then data 0xDEADBEEF, sel F.
  - Required: exactly 2 egress_rd_o[1] pulses; one mem cycle with mem_we_o=1, adr 0x100, data DEADBEEF, sel F, mem_last_o=1; busy_o low after.
- Wrap4 read, port 0:
  - Stimulus: adr=0x0A2, mem_ack_i tied 1.
  - Required: mem_adr_o 0x0A2, 0x0A3, 0x0A0, 0x0A1 on consecutive cycles; 4 ingress_wr_o[0] pulses carrying the mem_dat_i values in order; mem_last_o only on 0x0A1.
- Round robin:
  - Stimulus: ports 0 and 2 non-empty simultaneously, pointer=0, port 0 refilled after its transaction.
  - Required: grant order 0, 2, 0.
- Write data underrun:
  - Stimulus: after header pop, egress_empty_i held 1 for 5 cycles.
  - Required: no pop and mem_req_o=0 throughout; data pop 1 cycle after empty falls.
- Ack stall:
  - Stimulus: mem_ack_i low 4 cycles during a wrap8 write word.
  - Required: mem_adr_o, mem_dat_o, and mem_sel_o unchanged; no extra pops.
- Linear burst and reset:
  - Stimulus: linear read at adr 0x3FFFFFFF with linear_len=8.
  - Required: address wraps to 0x00000000 on the 2nd word.
  - Stimulus: sdram_rst asserted after 3 acks.
  - Required: all outputs 0 without a clock edge; next grant starts from port 0.
